// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, MDU FSM states and opcode-class
// helpers shared by the execute-stage files.
package ex_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT,
                      OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                      OP_OR, OP_AND};
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: magnitude operand/partial registers, counter
// and shift-add / restoring-divide step datapath.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_step,
`ifdef EX_MDU_DIV_EN
  input  logic            i_div,
`endif
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_last
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);

  logic [2*XLEN-1:0] hl_q, hl_d, hl;
  logic [XLEN-1:0]   m_q, m_d;
  logic [CW-1:0]     cnt_q, cnt_d;
`ifdef EX_MDU_DIV_EN
  logic              div_q, div_d;
`endif

  // hi accumulates, lo holds multiplier bits and
  // collects the low product bits as they shift in
  function automatic logic [2*XLEN-1:0] mul_step(
    input logic [2*XLEN-1:0] x,
    input logic [XLEN-1:0]   m
  );
    logic [XLEN:0] t;
    t = {1'b0, x[2*XLEN-1:XLEN]}
      + (x[0] ? {1'b0, m} : '0);
    return {t, x[XLEN-1:1]};
  endfunction

`ifdef EX_MDU_DIV_EN
  // hi is the partial remainder, lo the dividend
  // that turns into the quotient bit by bit
  function automatic logic [2*XLEN-1:0] div_step(
    input logic [2*XLEN-1:0] x,
    input logic [XLEN-1:0]   m
  );
    logic [XLEN:0] t;
    t = x[2*XLEN-1:XLEN-1] - {1'b0, m};
    if (t[XLEN])
      return {x[2*XLEN-2:0], 1'b0};
    return {t[XLEN-1:0], x[XLEN-2:0], 1'b1};
  endfunction
`endif

  // load on start, retire BITS_PER_CYCLE bits per step
  always_comb begin
    hl_d  = hl_q;
    m_d   = m_q;
    cnt_d = cnt_q;
`ifdef EX_MDU_DIV_EN
    div_d = div_q;
`endif
    hl    = hl_q;
    if (i_start) begin
      cnt_d = '0;
`ifdef EX_MDU_DIV_EN
      div_d = i_div;
      hl_d  = {{XLEN{1'b0}}, i_div ? i_a : i_b};
      m_d   = i_div ? i_b : i_a;
`else
      hl_d  = {{XLEN{1'b0}}, i_b};
      m_d   = i_a;
`endif
    end else if (i_step) begin
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
`ifdef EX_MDU_DIV_EN
        hl = div_q ? div_step(hl, m_q)
                   : mul_step(hl, m_q);
`else
        hl = mul_step(hl, m_q);
`endif
      end
      hl_d  = hl;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hl_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
`ifdef EX_MDU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      hl_q  <= hl_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
`ifdef EX_MDU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign o_hi   = hl_q[2*XLEN-1:XLEN];
  assign o_lo   = hl_q[XLEN-1:0];
  assign o_last = (cnt_q == CW'(N-1));

endmodule

// File: rtl/ex_alu_mdu.sv
// ex_alu_mdu: single-cycle ALU plus iterative RV32M unit.
// Divide support is built only with EX_MDU_DIV_EN defined.
module ex_alu_mdu
  import ex_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_illegal
);

  localparam int SHW = $clog2(XLEN);

  mdu_state_t        state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_p_q, neg_p_d;
`ifdef EX_MDU_DIV_EN
  logic              neg_r_q, neg_r_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   quo, rem;
`endif
  logic              valid_q, valid_d;
  logic              ill_q, ill_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        ord_q, ord_d;

  logic              accept, is_m, legal;
  logic              sa, sb, start, step, last;
  logic [XLEN-1:0]   a_mag, b_mag, hi, lo;
  logic [XLEN-1:0]   alu_res, fix_res;
  logic [SHW-1:0]    shamt;
  logic [2*XLEN-1:0] prod;

`ifdef EX_MDU_DIV_EN
  assign is_m = is_mul(i_op) || is_div(i_op);
`else
  assign is_m = is_mul(i_op);
`endif
  assign legal   = is_alu(i_op) || is_m;
  assign o_ready = !i_reset && (state_q == S_IDLE);
  assign accept  = i_valid && o_ready && !i_flush;

  assign sa    = is_signed_a(i_op) && i_a[XLEN-1];
  assign sb    = is_signed_b(i_op) && i_b[XLEN-1];
  assign a_mag = sa ? -i_a : i_a;
  assign b_mag = sb ? -i_b : i_b;
  assign shamt = i_b[SHW-1:0];

  mdu_iter #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_iter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (start),
    .i_step  (step),
`ifdef EX_MDU_DIV_EN
    .i_div   (is_div(i_op)),
`endif
    .i_a     (a_mag),
    .i_b     (b_mag),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_last  (last)
  );

  // single-cycle integer ALU
  always_comb begin
    alu_res = '0;
    unique case (i_op)
      OP_ADD:  alu_res = i_a + i_b;
      OP_SUB:  alu_res = i_a - i_b;
      OP_SLL:  alu_res = i_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                 $signed(i_a) < $signed(i_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}},
                 i_a < i_b};
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_SRL:  alu_res = i_a >> shamt;
      OP_SRA:  alu_res = $signed(i_a) >>> shamt;
      OP_OR:   alu_res = i_a | i_b;
      OP_AND:  alu_res = i_a & i_b;
      default: alu_res = '0;
    endcase
  end

  // sign fix-up and half / quotient-remainder select
  always_comb begin
    prod = {hi, lo};
    if (neg_p_q)
      prod = -prod;
    fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0]
                               : prod[2*XLEN-1:XLEN];
`ifdef EX_MDU_DIV_EN
    quo = neg_p_q ? -lo : lo;
    rem = neg_r_q ? -hi : hi;
    if (div0_q)
      quo = '1;
    if (is_div(op_q))
      fix_res = (op_q == OP_DIV || op_q == OP_DIVU)
                ? quo : rem;
`endif
  end

  // handshake, MDU sequencing and result selection
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_p_d = neg_p_q;
`ifdef EX_MDU_DIV_EN
    neg_r_d = neg_r_q;
    div0_d  = div0_q;
`endif
    valid_d = 1'b0;
    ill_d   = 1'b0;
    res_d   = res_q;
    ord_d   = ord_q;
    start   = 1'b0;
    step    = 1'b0;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && is_m) begin
            start   = 1'b1;
            state_d = S_BUSY;
            op_d    = i_op;
            rd_d    = i_rd;
            neg_p_d = sa ^ sb;
`ifdef EX_MDU_DIV_EN
            neg_r_d = sa;
            div0_d  = (i_b == '0);
`endif
          end else if (accept) begin
            valid_d = 1'b1;
            ill_d   = !legal;
            res_d   = legal ? alu_res : '0;
            ord_d   = i_rd;
          end
        end
        S_BUSY: begin
          step = 1'b1;
          if (last)
            state_d = S_FIX;
        end
        S_FIX: begin
          valid_d = 1'b1;
          res_d   = fix_res;
          ord_d   = rd_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      neg_p_q <= 1'b0;
`ifdef EX_MDU_DIV_EN
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
`endif
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      res_q   <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_p_q <= neg_p_d;
`ifdef EX_MDU_DIV_EN
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
`endif
      valid_q <= valid_d;
      ill_q   <= ill_d;
      res_q   <= res_d;
      ord_q   <= ord_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_illegal = ill_q;
  assign o_result  = res_q;
  assign o_rd      = ord_q;

endmodule

// File: doc/ex_alu_mdu.md
# ex_alu_mdu

Parametrised execute unit for the RV32 pipeline. It combines a single-cycle integer ALU with an iterative RV32M multiply/divide unit. It sits between the EX pipeline register and the MEM stage, and accepts one operation per handshake. It stalls upstream through `o_ready` while a multi-cycle M-extension operation is in flight, and returns one registered result pulse per operation.

## Interface
- `XLEN`, default 32: operand/result width (power of two, ≥ 8).
- `BITS_PER_CYCLE`, default 1: multiply/divide bits retired per iteration; one of 1, 2, 4; must divide `XLEN`.
- `i_clk` in 1: single clock, all state on rising edge.
- `i_reset` in 1: reset is synchronous and active-high.
- `i_valid` in 1: operation presented this cycle.
- `o_ready` out 1: unit can accept; transfer occurs when `i_valid && o_ready`.
- `i_op` in 5: `alu_op_t` opcode (see Structure).
- `i_a`, `i_b` in XLEN: operands (`rs1`, `rs2`/immediate already muxed upstream).
- `i_rd` in 5: destination tag, carried to output.
- `i_flush` in 1: kill any accepted, not-yet-returned operation.
- `o_valid` out 1: one-cycle result strobe.
- `o_result` out XLEN: result, meaningful only when `o_valid`.
- `o_rd` out 5: tag of returned result.
- `o_illegal` out 1: one-cycle strobe with `o_valid` for an unsupported opcode.

## Operation
- ALU ops are ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount is `i_b[$clog2(XLEN)-1:0]`.
  - SRA replicates `i_a[XLEN-1]` into every vacated bit.
  - Result is registered; `o_ready` stays high.
- M ops are MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. The FSM has three states:
  - IDLE (`o_ready`=1). On accept of an M op, latch operands, record signs, take absolute values as required, clear the counter, and move to BUSY.
  - BUSY (`o_ready`=0). Each cycle retires `BITS_PER_CYCLE` bits of shift-add multiply or restoring divide. The counter increments; at `XLEN/BITS_PER_CYCLE` iterations, move to FIX.
  - FIX (`o_ready`=0). Apply sign correction, select the low/high product or quotient/remainder, drive `o_valid`, and return to IDLE.
- Product is a 2·XLEN-bit internal value. MUL returns the low half; the MULH variants return the high half with the signedness per opcode.
- Divide by zero: quotient is all ones; remainder is `i_a`.
- Signed overflow (−2^(XLEN−1) ÷ −1): quotient is `i_a`; remainder is 0.
- Opcode outside the defined set: `o_result`=0, `o_illegal`=1, single-cycle latency.
- `i_flush`:
  - Forces IDLE.
  - Suppresses any `o_valid` that would appear in the next cycle.
  - Blocks acceptance in the same cycle.
  - Has priority over both accept and FIX.
- Reset:
  - In the reset cycle: state IDLE; `o_valid`, `o_illegal`, `o_result`, `o_rd` all 0; `o_ready`=0.
  - From the first cycle after reset deasserts: `o_ready`=1.
  - Reset mid-operation abandons it with no output.

## Timing
- ALU op accepted at edge T: `o_valid` is high in the cycle after T. Back-to-back ALU ops give one result per cycle.
- M op accepted at edge T: `o_valid` is high in the cycle after edge T + `XLEN/BITS_PER_CYCLE` + 1. For the defaults that is 34 cycles after T.
- `o_ready` is low from the cycle after accept through FIX. It returns high in the same cycle as `o_valid`, so a new op may be accepted alongside the result.
- No output backpressure: the consumer must take `o_valid` when asserted.

## Configuration
- `EX_MDU_DIV_EN`:
  - Defined: DIV/DIVU/REM/REMU execute as above.
  - Undefined: the divide datapath is removed, and the four divide opcodes are treated as illegal (`o_illegal`=1, result 0, single-cycle). Multiply is unaffected.

## Structure
- Package `ex_pkg`: the `alu_op_t` enum (5-bit, explicit encodings), the FSM state enum, and opcode-class helper functions (`is_mul`, `is_div`, `is_signed_a`, `is_signed_b`).
- Sub-module `mdu_iter`: operand registers, iteration counter, and the shift-add/restoring-divide step logic. `ex_alu_mdu` holds the ALU, handshake, FSM, and sign fix-up.

## Test plan
- ADD 0x7FFFFFFF + 1 then SRA 0x80000000 >> 4 back-to-back: results 0x80000000 and 0xF8000000 on consecutive cycles, `o_ready` never low.
- MULH 0xFFFFFFFF × 0xFFFFFFFF (signed): `o_result`=0x00000000 exactly 34 cycles after accept; MULHU on the same operands gives 0xFFFFFFFE.
- DIV −7 ÷ 2 → 0xFFFFFFFD; REM −7 ÷ 2 → 0xFFFFFFFF; DIVU 5 ÷ 0 → 0xFFFFFFFF; REM 5 ÷ 0 → 5.
- DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Assert `i_flush` 10 cycles into a DIV: no `o_valid`, `o_ready` high next cycle, following ADD 2+3 returns 5 one cycle later.
- Build without `EX_MDU_DIV_EN`: DIVU 9 ÷ 3 → `o_valid` and `o_illegal` high one cycle after accept, result 0; MUL 3 × 3 still returns 9.
